// File: rtl/enc_pkg.sv
// Shared types and helpers for the clocked 4-to-2 priority encoder.
package enc_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Index of the highest set bit; 3 wins over 2 over 1 over 0.
    function automatic logic [1:0] prio4(input logic [N_REQ-1:0] p);
        logic [1:0] idx;
        idx = 2'd0;
        if (p[3])      idx = 2'd3;
        else if (p[2]) idx = 2'd2;
        else if (p[1]) idx = 2'd1;
        return idx;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder with an any-bit-set flag.
module prio_enc4
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    output logic [1:0]       code,
    output logic             any
);

    assign code = prio4(req);
    assign any  = |req;

endmodule

// File: rtl/enc_4s2_sync.sv
// Clocked 4-to-2 priority encoder: captures request pulses as pending bits and
// presents one code at a time behind a V/ACK handshake.
module enc_4s2_sync
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             I3,
    input  logic             I2,
    input  logic             I1,
    input  logic             I0,
    input  logic             ACK,
    output logic             Y1,
    output logic             Y0,
    output logic             V,
    output logic             OVR,
    output logic [N_REQ-1:0] PEND
);

    state_t           state;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] lost;
    logic [1:0]       top_code;
    logic             top_any;

    assign req = {I3, I2, I1, I0};

    prio_enc4 u_prio (
        .req  (PEND),
        .code (top_code),
        .any  (top_any)
    );

    // NOTE: assign the default before the conditional so no latch is inferred.
    always_comb begin
        clr = '0;
        if (state == ST_HOLD && ACK) clr[{Y1, Y0}] = 1'b1;
    end

    // A new pulse on a line that is still pending and not being cleared is lost.
    assign lost = req & PEND & ~clr;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            PEND  <= '0;
            OVR   <= 1'b0;
            V     <= 1'b0;
            Y1    <= 1'b0;
            Y0    <= 1'b0;
        end else begin
            PEND <= req | (PEND & ~clr);
            if (|lost) OVR <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (top_any) begin
                        {Y1, Y0} <= top_code;
                        V        <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ACK) begin
                        V     <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    V     <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_4s2_sync.sv
// Self-checking bench for enc_4s2_sync: directed vector table, then random
// traffic compared against a behavioural pending-set model.
module tb_enc_4s2_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i_in = 4'b0;
    logic       ack = 1'b0;
    logic       y1, y0, v, ovr;
    logic [3:0] pend;

    int n_assert = 0;
    int n_fail   = 0;

    enc_4s2_sync dut (
        .clk  (clk),
        .rst  (rst),
        .I3   (i_in[3]),
        .I2   (i_in[2]),
        .I1   (i_in[1]),
        .I0   (i_in[0]),
        .ACK  (ack),
        .Y1   (y1),
        .Y0   (y0),
        .V    (v),
        .OVR  (ovr),
        .PEND (pend)
    );

    always #5 clk = ~clk;

    // Reference model: a set of outstanding requests plus the code on offer.
    bit m_pend [4];
    bit m_valid;
    int m_code;
    bit m_ovr;

    task automatic model_step(input bit r, input logic [3:0] ii, input bit a);
        bit nxt [4];
        bit served;
        if (r) begin
            foreach (m_pend[k]) m_pend[k] = 0;
            m_valid = 0;
            m_code  = 0;
            m_ovr   = 0;
            return;
        end
        served = m_valid && a;
        for (int k = 0; k < 4; k++) begin
            bit taken;
            taken  = served && (m_code == k);
            nxt[k] = ii[k] || (m_pend[k] && !taken);
            if (ii[k] && m_pend[k] && !taken) m_ovr = 1;
        end
        if (m_valid) begin
            if (a) m_valid = 0;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (m_pend[k] && !m_valid) begin
                    m_valid = 1;
                    m_code  = k;
                end
            end
        end
        foreach (m_pend[k]) m_pend[k] = nxt[k];
    endtask

    function automatic logic [3:0] model_pend_vec();
        logic [3:0] p;
        foreach (m_pend[k]) p[k] = m_pend[k];
        return p;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, step the model at the rising edge,
    // leave outputs settled 1 time unit later for sampling.
    task automatic cycle(input bit r, input logic [3:0] ii, input bit a);
        @(negedge clk);
        rst  = r;
        i_in = ii;
        ack  = a;
        @(posedge clk);
        model_step(r, ii, a);
        #1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] i;
        bit         ack;
        bit         v;
        logic [1:0] y;
        bit         y_care;
        logic [3:0] pend;
        bit         ovr;
    } vec_t;

    function automatic vec_t mk(bit r, logic [3:0] ii, bit a, bit ev,
                                logic [1:0] ey, bit yc, logic [3:0] ep, bit eo);
        vec_t t;
        t.rst = r; t.i = ii; t.ack = a; t.v = ev;
        t.y = ey; t.y_care = yc; t.pend = ep; t.ovr = eo;
        return t;
    endfunction

    vec_t vecs [30];

    initial begin
        // Columns: rst, I[3:0], ACK | expected after the edge: V, Y, Y checked, PEND, OVR
        vecs[0]  = mk(1, 4'b1111, 0, 0, 2'd0, 1, 4'b0000, 0);  // reset with all lines high
        vecs[1]  = mk(1, 4'b1111, 0, 0, 2'd0, 1, 4'b0000, 0);
        vecs[2]  = mk(0, 4'b0010, 0, 0, 2'd0, 1, 4'b0010, 0);  // single I1 request
        vecs[3]  = mk(0, 4'b0000, 0, 1, 2'd1, 1, 4'b0010, 0);
        vecs[4]  = mk(0, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 0);
        vecs[5]  = mk(0, 4'b1101, 1, 0, 2'd0, 0, 4'b1101, 0);  // I3,I2,I0 together, ACK high
        vecs[6]  = mk(0, 4'b0000, 1, 1, 2'd3, 1, 4'b1101, 0);
        vecs[7]  = mk(0, 4'b0000, 1, 0, 2'd0, 0, 4'b0101, 0);
        vecs[8]  = mk(0, 4'b0000, 1, 1, 2'd2, 1, 4'b0101, 0);
        vecs[9]  = mk(0, 4'b0000, 1, 0, 2'd0, 0, 4'b0001, 0);
        vecs[10] = mk(0, 4'b0000, 1, 1, 2'd0, 1, 4'b0001, 0);
        vecs[11] = mk(0, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 0);
        vecs[12] = mk(0, 4'b0001, 0, 0, 2'd0, 0, 4'b0001, 0);  // no pre-emption
        vecs[13] = mk(0, 4'b0000, 0, 1, 2'd0, 1, 4'b0001, 0);
        vecs[14] = mk(0, 4'b1000, 0, 1, 2'd0, 1, 4'b1001, 0);
        vecs[15] = mk(0, 4'b0000, 0, 1, 2'd0, 1, 4'b1001, 0);
        vecs[16] = mk(0, 4'b0000, 1, 0, 2'd0, 0, 4'b1000, 0);
        vecs[17] = mk(0, 4'b0000, 0, 1, 2'd3, 1, 4'b1000, 0);
        vecs[18] = mk(0, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 0);
        vecs[19] = mk(0, 4'b0100, 0, 0, 2'd0, 0, 4'b0100, 0);  // set-dominance on the ACK edge
        vecs[20] = mk(0, 4'b0000, 0, 1, 2'd2, 1, 4'b0100, 0);
        vecs[21] = mk(0, 4'b0100, 1, 0, 2'd0, 0, 4'b0100, 0);
        vecs[22] = mk(0, 4'b0000, 0, 1, 2'd2, 1, 4'b0100, 0);
        vecs[23] = mk(0, 4'b0100, 0, 1, 2'd2, 1, 4'b0100, 1);  // overrun: repeat I2 while pending
        vecs[24] = mk(0, 4'b0000, 0, 1, 2'd2, 1, 4'b0100, 1);
        vecs[25] = mk(0, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1);
        vecs[26] = mk(0, 4'b1000, 0, 0, 2'd0, 0, 4'b1000, 1);  // reset mid-HOLD
        vecs[27] = mk(0, 4'b0000, 0, 1, 2'd3, 1, 4'b1000, 1);
        vecs[28] = mk(1, 4'b0000, 0, 0, 2'd0, 1, 4'b0000, 0);
        vecs[29] = mk(0, 4'b0000, 0, 0, 2'd0, 1, 4'b0000, 0);

        foreach (m_pend[k]) m_pend[k] = 0;
        m_valid = 0;
        m_code  = 0;
        m_ovr   = 0;

        for (int n = 0; n < 30; n++) begin
            cycle(vecs[n].rst, vecs[n].i, vecs[n].ack);
            check($sformatf("vec%0d V", n),    {7'b0, v},    {7'b0, vecs[n].v});
            check($sformatf("vec%0d PEND", n), {4'b0, pend}, {4'b0, vecs[n].pend});
            check($sformatf("vec%0d OVR", n),  {7'b0, ovr},  {7'b0, vecs[n].ovr});
            if (vecs[n].y_care)
                check($sformatf("vec%0d Y", n), {6'b0, y1, y0}, {6'b0, vecs[n].y});
        end

        // Random traffic; sparse pulses keep overrun from saturating immediately.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] ii;
            bit r, a;
            r = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 4; k++) ii[k] = ($urandom_range(0, 5) == 0);
            a = $urandom_range(0, 1) == 1;
            cycle(r, ii, a);
            check($sformatf("rnd%0d V", n),    {7'b0, v},    {7'b0, m_valid});
            check($sformatf("rnd%0d PEND", n), {4'b0, pend}, {4'b0, model_pend_vec()});
            check($sformatf("rnd%0d OVR", n),  {7'b0, ovr},  {7'b0, m_ovr});
            if (m_valid)
                check($sformatf("rnd%0d Y", n), {6'b0, y1, y0}, 8'(m_code));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
